fir_coef_sequencer: RTL and testbench
=====================================

// Module: fir_coef_sequencer
// PURPOSE
//  Single-clock controller in front of fir_core. Owns the coefficient load port and the sample-issue port.
//  Host writes 64 coefficients into a shadow bank at any time. A commit streams the bank into fir_core
//  via cload/caddr/cin, but never while a sample is being computed.
//  Samples arriving during a load are held and issued afterwards.
// PARAMETERS
//  NUM_TAPS   64      coefficient count; address width = $clog2(NUM_TAPS)
//  DW         16      sample and coefficient width (signed)
//  TIMEOUT    1024    max clk2 cycles from fir_valid_in to fir_valid_out before timeout error
// PORTS
//  clk2          in   1    sole clock (fir_core compute clock)
//  rstn          in   1    asynchronous, active-low reset
//  host_we       in   1    shadow-bank write strobe
//  host_addr     in   6    shadow-bank address
//  host_data     in   DW   coefficient value
//  commit        in   1    1-cycle pulse: request shadow->fir_core load
//  s_valid       in   1    1-cycle sample strobe, already synchronous to clk2
//  s_data        in   DW   sample value
//  fir_valid_out in   1    fir_core result strobe
//  err_clr       in   1    clears all sticky error bits
//  fir_din       out  DW   sample to fir_core
//  fir_valid_in  out  1    1-cycle sample-issue pulse
//  fir_cin       out  DW   coefficient to fir_core
//  fir_caddr     out  6    coefficient address
//  fir_cload     out  1    coefficient write enable
//  load_done     out  1    1-cycle pulse after the last coefficient is written
//  busy          out  1    high in any state other than IDLE, or while a sample/commit is pending
//  err           out  3    sticky {timeout, host-write-during-load, sample overflow}
// BEHAVIOUR
//  Reset: every output is 0. Shadow bank is 0. FSM is IDLE. hold_valid=0, commit_pend=0.
//  FSM states: IDLE, RUN (sample in flight), LOAD (streaming coefficients).
//  IDLE:
//   - Issue a sample if s_valid or hold_valid: fir_din=data, fir_valid_in=1 for one cycle, go to RUN.
//     A held sample has priority over a new s_valid; the new one is then held instead.
//   - Else if commit or commit_pend: go to LOAD with k=0.
//   - Sample beats commit in the same cycle: the commit becomes pending.
//  RUN:
//   - A timer counts cycles.
//   - fir_valid_out -> go to IDLE.
//   - Timer reaches TIMEOUT-1 -> set err[2] and go to IDLE.
//   - commit here sets commit_pend.
//   - s_valid here loads the hold register.
//  LOAD:
//   - Cycle k (k=0..NUM_TAPS-1): fir_cload=1, fir_caddr=k, fir_cin=shadow[k].
//   - After k=NUM_TAPS-1: load_done=1 for one cycle, clear commit_pend, go to IDLE.
//   - Total: NUM_TAPS cycles of cload, then 1 cycle of load_done.
//   - s_valid here loads the hold register. A repeated commit is ignored (no restart).
//  Hold register: single entry.
//   - s_valid while hold_valid=1 and not draining -> the new sample is dropped and err[0] is set.
//   - The held sample is kept.
//  Host writes:
//   - Accepted in IDLE and RUN. The write lands at the clock edge.
//   - During LOAD the write is dropped and err[1] is set, so the bank stays consistent with the load.
//   - A write and a commit in the same IDLE cycle: the write lands first and the load uses the new value.
//  Idle outputs: when not issuing, fir_valid_in=0 and fir_cload=0. fir_caddr/fir_cin hold their last values.
//  err_clr clears err. If err_clr and a new error occur in the same cycle, the set wins.
//  rstn asserted mid-LOAD: the load aborts at once (cload=0) and no load_done pulse is produced.
//   The bank resets to 0, so a re-commit is required.
//  All outputs are registered. Sample-issue latency is 1 cycle from s_valid in IDLE.
// STRUCTURE
//  Shared package fir_pkg: NUM_TAPS, DW, AW, FSM state enum, err bit indices.
//  One natural sub-module: fir_coef_bank (NUM_TAPS x DW register file).
//   - 1 write port (host).
//   - 1 combinational read port (sequencer address k).
//  The FSM, timer, hold register and error logic sit in the top module.
// TESTING
//  1. Write 64 x 0x0100, commit in IDLE -> 64 consecutive cload cycles, caddr 0..63, cin=0x0100;
//     load_done exactly 1 cycle after caddr=63.
//  2. s_valid(0x1000) in IDLE -> fir_valid_in next cycle, fir_din=0x1000, busy=1.
//     Model valid_out after 70 cycles -> IDLE.
//  3. commit during RUN -> no cload until fir_valid_out.
//     LOAD starts the cycle after IDLE is re-entered, and busy stays high throughout.
//  4. s_valid at cycle 10 of LOAD -> sample issued the cycle after load_done.
//     A second s_valid during the same LOAD -> err=3'b001 and the first sample is issued.
//  5. host_we at LOAD cycle 5 to addr 40 -> err=3'b010 and cin at caddr=40 keeps the old value.
//     err_clr -> err=0.
//  6. Withhold fir_valid_out -> err=3'b100 after TIMEOUT cycles, FSM back in IDLE.
//     rstn pulse mid-LOAD -> all outputs 0 and no load_done.

Source files
------------

// File: rtl/fir_coef_sequencer_pkg.sv
// Shared constants, FSM encoding and request types for the FIR coefficient sequencer.
package fir_coef_sequencer_pkg;
  localparam int NUM_TAPS = 64;
  localparam int DW       = 16;
  localparam int AW       = $clog2(NUM_TAPS);
  localparam int TIMEOUT  = 1024;

  localparam int ERR_OVF = 0;
  localparam int ERR_HWR = 1;
  localparam int ERR_TO  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } host_wr_t;
endpackage

// File: rtl/fir_coef_sequencer_if.sv
// Host, sample and fir_core-side signals of the sequencer bundled as one interface.
interface fir_coef_sequencer_if;
  import fir_coef_sequencer_pkg::*;

  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          commit;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          fir_valid_out;
  logic          err_clr;

  logic [DW-1:0] fir_din;
  logic          fir_valid_in;
  logic [DW-1:0] fir_cin;
  logic [AW-1:0] fir_caddr;
  logic          fir_cload;
  logic          load_done;
  logic          busy;
  logic [2:0]    err;

  modport master (
    output host_we, host_addr, host_data, commit, s_valid, s_data, fir_valid_out, err_clr,
    input  fir_din, fir_valid_in, fir_cin, fir_caddr, fir_cload, load_done, busy, err
  );

  modport slave (
    input  host_we, host_addr, host_data, commit, s_valid, s_data, fir_valid_out, err_clr,
    output fir_din, fir_valid_in, fir_cin, fir_caddr, fir_cload, load_done, busy, err
  );
endinterface

// File: rtl/fir_coef_sequencer_bank.sv
// Shadow coefficient register file: one synchronous write port, one combinational read port.
module fir_coef_bank #(
  parameter int TAPS  = 64,
  parameter int WIDTH = 16,
  parameter int BAW   = $clog2(TAPS)
) (
  input  logic             clk2,
  input  logic             rstn,
  input  logic             i_we,
  input  logic [BAW-1:0]   i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [BAW-1:0]   i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [TAPS-1:0][WIDTH-1:0] r_mem;

  for (genvar g = 0; g < TAPS; g++) begin : g_ent
    always_ff @(posedge clk2 or negedge rstn) begin
      if (!rstn)                              r_mem[g] <= '0;
      else if (i_we && i_waddr == BAW'(g))    r_mem[g] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fir_coef_sequencer.sv
// Sequencer in front of fir_core: issues samples, streams the shadow coefficient bank on commit,
// and never overlaps a coefficient load with an in-flight sample.
module fir_coef_sequencer
  import fir_coef_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT
) (
  input  logic                 clk2,
  input  logic                 rstn,
  fir_coef_sequencer_if.slave  bus
);
  localparam int              TW     = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYC - 1);
  // k runs one past the last tap so the load_done beat gets its own cycle
  localparam logic [AW:0]     K_DONE = (AW+1)'(NUM_TAPS);

  state_e        r_state, w_state_nx;
  logic [AW:0]   r_k, w_k_nx;
  logic [TW-1:0] r_timer, w_timer_nx;
  logic          r_hold_vld, w_hold_vld_nx;
  logic [DW-1:0] r_hold_data, w_hold_data_nx;
  logic          r_commit_pend, w_commit_pend_nx;

  logic [DW-1:0] r_fir_din, w_fir_din_nx;
  logic          r_fir_valid_in, w_fir_valid_in_nx;
  logic [DW-1:0] r_fir_cin, w_fir_cin_nx;
  logic [AW-1:0] r_fir_caddr, w_fir_caddr_nx;
  logic          r_fir_cload, w_fir_cload_nx;
  logic          r_load_done, w_load_done_nx;
  logic          r_busy, w_busy_nx;
  logic [2:0]    r_err, w_err_nx, w_err_set;

  host_wr_t      w_wr;
  logic [DW-1:0] w_bank_rdata;

  // Host writes are dropped during LOAD so the streamed bank stays self-consistent
  always_comb begin
    w_wr.we   = bus.host_we && (r_state != ST_LOAD);
    w_wr.addr = bus.host_addr;
    w_wr.data = bus.host_data;
  end

  fir_coef_bank #(.TAPS(NUM_TAPS), .WIDTH(DW)) u_bank (
    .clk2    (clk2),
    .rstn    (rstn),
    .i_we    (w_wr.we),
    .i_waddr (w_wr.addr),
    .i_wdata (w_wr.data),
    .i_raddr (r_k[AW-1:0]),
    .o_rdata (w_bank_rdata)
  );

  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      r_state        <= ST_IDLE;
      r_k            <= '0;
      r_timer        <= '0;
      r_hold_vld     <= 1'b0;
      r_hold_data    <= '0;
      r_commit_pend  <= 1'b0;
      r_fir_din      <= '0;
      r_fir_valid_in <= 1'b0;
      r_fir_cin      <= '0;
      r_fir_caddr    <= '0;
      r_fir_cload    <= 1'b0;
      r_load_done    <= 1'b0;
      r_busy         <= 1'b0;
      r_err          <= '0;
    end else begin
      r_state        <= w_state_nx;
      r_k            <= w_k_nx;
      r_timer        <= w_timer_nx;
      r_hold_vld     <= w_hold_vld_nx;
      r_hold_data    <= w_hold_data_nx;
      r_commit_pend  <= w_commit_pend_nx;
      r_fir_din      <= w_fir_din_nx;
      r_fir_valid_in <= w_fir_valid_in_nx;
      r_fir_cin      <= w_fir_cin_nx;
      r_fir_caddr    <= w_fir_caddr_nx;
      r_fir_cload    <= w_fir_cload_nx;
      r_load_done    <= w_load_done_nx;
      r_busy         <= w_busy_nx;
      r_err          <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx        = r_state;
    w_k_nx            = r_k;
    w_timer_nx        = r_timer;
    w_hold_vld_nx     = r_hold_vld;
    w_hold_data_nx    = r_hold_data;
    w_commit_pend_nx  = r_commit_pend;
    w_fir_din_nx      = r_fir_din;
    w_fir_valid_in_nx = 1'b0;
    w_fir_cin_nx      = r_fir_cin;
    w_fir_caddr_nx    = r_fir_caddr;
    w_fir_cload_nx    = 1'b0;
    w_load_done_nx    = 1'b0;
    w_err_set         = '0;

    case (r_state)
      ST_IDLE: begin
        if (r_hold_vld || bus.s_valid) begin
          w_fir_valid_in_nx = 1'b1;
          w_state_nx        = ST_RUN;
          w_timer_nx        = '0;
          if (r_hold_vld) begin
            // held sample drains first; a concurrent arrival takes its slot
            w_fir_din_nx   = r_hold_data;
            w_hold_vld_nx  = bus.s_valid;
            w_hold_data_nx = bus.s_valid ? bus.s_data : r_hold_data;
          end else begin
            w_fir_din_nx   = bus.s_data;
          end
          if (bus.commit) w_commit_pend_nx = 1'b1;
        end else if (bus.commit || r_commit_pend) begin
          w_state_nx = ST_LOAD;
          w_k_nx     = '0;
        end
      end
      ST_RUN: begin
        if (bus.commit) w_commit_pend_nx = 1'b1;
        if (bus.fir_valid_out) begin
          w_state_nx = ST_IDLE;
        end else if (r_timer == T_LAST) begin
          w_err_set[ERR_TO] = 1'b1;
          w_state_nx        = ST_IDLE;
        end else begin
          w_timer_nx = r_timer + 1'b1;
        end
      end
      ST_LOAD: begin
        if (bus.host_we) w_err_set[ERR_HWR] = 1'b1;
        if (r_k == K_DONE) begin
          w_load_done_nx   = 1'b1;
          w_commit_pend_nx = 1'b0;
          w_state_nx       = ST_IDLE;
        end else begin
          w_fir_cload_nx = 1'b1;
          w_fir_caddr_nx = r_k[AW-1:0];
          w_fir_cin_nx   = w_bank_rdata;
          w_k_nx         = r_k + 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase

    // Samples outside IDLE park in the single-entry hold register
    if (bus.s_valid && r_state != ST_IDLE) begin
      if (r_hold_vld) begin
        w_err_set[ERR_OVF] = 1'b1;
      end else begin
        w_hold_vld_nx  = 1'b1;
        w_hold_data_nx = bus.s_data;
      end
    end

    w_err_nx  = (r_err & {3{~bus.err_clr}}) | w_err_set;
    w_busy_nx = (w_state_nx != ST_IDLE) || w_hold_vld_nx || w_commit_pend_nx;
  end

  assign bus.fir_din      = r_fir_din;
  assign bus.fir_valid_in = r_fir_valid_in;
  assign bus.fir_cin      = r_fir_cin;
  assign bus.fir_caddr    = r_fir_caddr;
  assign bus.fir_cload    = r_fir_cload;
  assign bus.load_done    = r_load_done;
  assign bus.busy         = r_busy;
  assign bus.err          = r_err;
endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Scenario bench for fir_coef_sequencer: randomized data checked against a bank/queue model.
module tb_fir_coef_sequencer;
  import fir_coef_sequencer_pkg::*;

  logic clk2 = 1'b0;
  logic rstn;
  always #5 clk2 = ~clk2;

  fir_coef_sequencer_if bus();
  fir_coef_sequencer dut (.clk2(clk2), .rstn(rstn), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DW-1:0] model_bank [NUM_TAPS];

  int            ld_addr_q[$];
  logic [DW-1:0] ld_data_q[$];
  int            ld_cyc_q[$];
  logic          ld_busy_q[$];
  int            done_cyc_q[$];
  logic [DW-1:0] iss_q[$];
  int            iss_cyc_q[$];

  always @(posedge clk2) cyc <= cyc + 1;

  always @(negedge clk2) begin
    if (bus.fir_cload === 1'b1) begin
      ld_addr_q.push_back(int'(bus.fir_caddr));
      ld_data_q.push_back(bus.fir_cin);
      ld_cyc_q.push_back(cyc);
      ld_busy_q.push_back(bus.busy);
    end
    if (bus.load_done === 1'b1) done_cyc_q.push_back(cyc);
    if (bus.fir_valid_in === 1'b1) begin
      iss_q.push_back(bus.fir_din);
      iss_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  task automatic clear_q();
    ld_addr_q.delete(); ld_data_q.delete(); ld_cyc_q.delete(); ld_busy_q.delete();
    done_cyc_q.delete(); iss_q.delete(); iss_cyc_q.delete();
  endtask

  task automatic idle_inputs();
    bus.host_we = 0; bus.host_addr = '0; bus.host_data = '0; bus.commit = 0;
    bus.s_valid = 0; bus.s_data = '0; bus.fir_valid_out = 0; bus.err_clr = 0;
  endtask

  task automatic write_bank(input int a, input logic [DW-1:0] v);
    bus.host_we = 1; bus.host_addr = AW'(a); bus.host_data = v;
    step();
    bus.host_we = 0;
    model_bank[a] = v;
  endtask

  task automatic pulse_commit();
    bus.commit = 1; step(); bus.commit = 0;
  endtask

  task automatic wait_done(output bit ok);
    for (int t = 0; t < 300; t++) begin
      if (bus.load_done === 1'b1) break;
      step();
    end
    ok = (bus.load_done === 1'b1);
  endtask

  task automatic wait_cload(output bit ok);
    for (int t = 0; t < 10; t++) begin
      if (bus.fir_cload === 1'b1) break;
      step();
    end
    ok = (bus.fir_cload === 1'b1);
  endtask

  task automatic test_reset();
    logic [2*DW+AW+15:0] outs;
    idle_inputs();
    rstn = 0;
    repeat (3) step();
    outs = {bus.fir_din, bus.fir_valid_in, bus.fir_cin, bus.fir_caddr, bus.fir_cload,
            bus.load_done, bus.busy, bus.err, 8'h00};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    rstn = 1;
    step();
    for (int i = 0; i < NUM_TAPS; i++) model_bank[i] = '0;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_load();
    bit ok;
    int a;
    logic [DW-1:0] v;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_TAPS; i++) write_bank(i, (pass == 0) ? 16'h0100 : DW'($urandom));
      clear_q();
      if (pass == 1) begin
        a = $urandom_range(0, NUM_TAPS-1); v = DW'($urandom);
        bus.host_we = 1; bus.host_addr = AW'(a); bus.host_data = v;
        model_bank[a] = v;
      end
      bus.commit = 1; step(); bus.commit = 0; bus.host_we = 0;
      wait_done(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL load_done_seen pass=%0d got=0 exp=1", pass); end
      step();
      checks++;
      if (ld_addr_q.size() != NUM_TAPS) begin
        failures++; $display("FAIL load_beats pass=%0d got=%0d exp=%0d", pass, ld_addr_q.size(), NUM_TAPS);
      end else begin
        for (int i = 0; i < NUM_TAPS; i++) begin
          checks++;
          if (ld_addr_q[i] !== i || ld_data_q[i] !== model_bank[i] || ld_cyc_q[i] !== ld_cyc_q[0] + i) begin
            failures++;
            $display("FAIL load_beat pass=%0d i=%0d got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d",
                     pass, i, ld_addr_q[i], ld_data_q[i], ld_cyc_q[i], i, model_bank[i], ld_cyc_q[0] + i);
          end
        end
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] !== ld_cyc_q[NUM_TAPS-1] + 1) begin
          failures++;
          $display("FAIL load_done_timing pass=%0d got n=%0d exp one pulse at cyc %0d",
                   pass, done_cyc_q.size(), ld_cyc_q[NUM_TAPS-1] + 1);
        end
      end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL load_busy_after pass=%0d got=%b exp=0", pass, bus.busy); end
    end
  endtask

  task automatic test_sample();
    logic [DW-1:0] d;
    int lat;
    for (int n = 0; n < 3; n++) begin
      d = DW'($urandom);
      lat = (n == 0) ? 70 : $urandom_range(2, 100);
      clear_q();
      bus.s_valid = 1; bus.s_data = d; step(); bus.s_valid = 0;
      checks++;
      if (bus.fir_valid_in !== 1'b1 || bus.fir_din !== d || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL sample_issue n=%0d got vin=%b din=%h busy=%b exp vin=1 din=%h busy=1",
                 n, bus.fir_valid_in, bus.fir_din, bus.busy, d);
      end
      step();
      checks++;
      if (bus.fir_valid_in !== 1'b0) begin failures++; $display("FAIL sample_pulse n=%0d got=%b exp=0", n, bus.fir_valid_in); end
      repeat (lat - 2) step();
      bus.fir_valid_out = 1; step(); bus.fir_valid_out = 0;
      checks++;
      if (bus.busy !== 1'b0 || bus.err !== 3'b000 || iss_q.size() != 1) begin
        failures++;
        $display("FAIL sample_complete n=%0d got busy=%b err=%b issues=%0d exp busy=0 err=0 issues=1",
                 n, bus.busy, bus.err, iss_q.size());
      end
    end
  endtask

  task automatic test_commit_in_run();
    bit ok;
    int n, vo, bad;
    clear_q();
    bus.s_valid = 1; bus.s_data = DW'($urandom); step(); bus.s_valid = 0;
    repeat (3) step();
    pulse_commit();
    n = $urandom_range(5, 40);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.fir_cload !== 1'b0 || bus.busy !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL run_no_cload got bad_cycles=%0d exp=0", bad); end
    bus.fir_valid_out = 1; step(); bus.fir_valid_out = 0;
    vo = cyc;
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL run_pending_busy got=%b exp=1", bus.busy); end
    wait_done(ok);
    step();
    checks++;
    if (!ok || ld_addr_q.size() != NUM_TAPS) begin
      failures++; $display("FAIL pend_load got done=%b beats=%0d exp done=1 beats=%0d", ok, ld_addr_q.size(), NUM_TAPS);
    end else begin
      checks++;
      if (ld_cyc_q[0] !== vo + 2) begin failures++; $display("FAIL pend_load_start got=%0d exp=%0d", ld_cyc_q[0], vo + 2); end
      bad = 0;
      foreach (ld_busy_q[i]) if (ld_busy_q[i] !== 1'b1) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL pend_load_busy got low_cycles=%0d exp=0", bad); end
    end
  endtask

  task automatic test_hold();
    bit ok;
    logic [DW-1:0] d1, d2, d3;
    d1 = DW'($urandom); d2 = DW'($urandom); d3 = DW'($urandom);
    clear_q();
    pulse_commit();
    wait_cload(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL hold_load_start got cload=0 exp=1"); end
    repeat (9) step();
    bus.s_valid = 1; bus.s_data = d1; step(); bus.s_valid = 0;
    checks++;
    if (bus.err !== 3'b000 || bus.fir_valid_in !== 1'b0) begin
      failures++; $display("FAIL hold_first got err=%b vin=%b exp err=000 vin=0", bus.err, bus.fir_valid_in);
    end
    repeat (10) step();
    bus.s_valid = 1; bus.s_data = d2; step(); bus.s_valid = 0;
    checks++;
    if (bus.err !== 3'b001) begin failures++; $display("FAIL hold_overflow got=%b exp=001", bus.err); end
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL hold_load_done got=0 exp=1"); end
    bus.s_valid = 1; bus.s_data = d3; step(); bus.s_valid = 0;
    checks++;
    if (bus.fir_valid_in !== 1'b1 || bus.fir_din !== d1) begin
      failures++; $display("FAIL hold_drain got vin=%b din=%h exp vin=1 din=%h", bus.fir_valid_in, bus.fir_din, d1);
    end
    bus.fir_valid_out = 1; step(); bus.fir_valid_out = 0;
    step();
    checks++;
    if (bus.fir_valid_in !== 1'b1 || bus.fir_din !== d3) begin
      failures++; $display("FAIL hold_second got vin=%b din=%h exp vin=1 din=%h", bus.fir_valid_in, bus.fir_din, d3);
    end
    bus.fir_valid_out = 1; step(); bus.fir_valid_out = 0;
    checks++;
    if (iss_q.size() != 2 || done_cyc_q.size() != 1 || iss_q[0] !== d1 || iss_q[1] !== d3 ||
        iss_cyc_q[0] !== done_cyc_q[0] + 1) begin
      failures++; $display("FAIL hold_order got issues=%0d exp %h,%h right after load_done", iss_q.size(), d1, d3);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 3'b001) begin
      failures++; $display("FAIL hold_end got busy=%b err=%b exp busy=0 err=001", bus.busy, bus.err);
    end
    bus.err_clr = 1; step(); bus.err_clr = 0;
    checks++;
    if (bus.err !== 3'b000) begin failures++; $display("FAIL hold_err_clr got=%b exp=000", bus.err); end
  endtask

  task automatic test_hostwr_load();
    bit ok;
    logic [DW-1:0] old, nv;
    old = model_bank[40];
    nv  = old ^ DW'($urandom_range(1, 65535));
    clear_q();
    pulse_commit();
    wait_cload(ok);
    repeat (5) step();
    bus.host_we = 1; bus.host_addr = AW'(40); bus.host_data = nv; step(); bus.host_we = 0;
    checks++;
    if (bus.err !== 3'b010) begin failures++; $display("FAIL hostwr_err got=%b exp=010", bus.err); end
    repeat (3) step();
    bus.host_we = 1; bus.host_addr = AW'(40); bus.host_data = DW'($urandom); bus.err_clr = 1;
    step();
    bus.host_we = 0; bus.err_clr = 0;
    checks++;
    if (bus.err !== 3'b010) begin failures++; $display("FAIL hostwr_set_wins got=%b exp=010", bus.err); end
    bus.err_clr = 1; step(); bus.err_clr = 0;
    checks++;
    if (bus.err !== 3'b000) begin failures++; $display("FAIL hostwr_err_clr got=%b exp=000", bus.err); end
    wait_done(ok);
    step();
    checks++;
    if (ld_addr_q.size() != NUM_TAPS) begin
      failures++; $display("FAIL hostwr_beats got=%0d exp=%0d", ld_addr_q.size(), NUM_TAPS);
    end else if (ld_addr_q[40] !== 40 || ld_data_q[40] !== old) begin
      failures++; $display("FAIL hostwr_keep got addr=%0d cin=%h exp addr=40 cin=%h", ld_addr_q[40], ld_data_q[40], old);
    end
  endtask

  task automatic test_timeout();
    int t0, n;
    bus.s_valid = 1; bus.s_data = DW'($urandom); step(); bus.s_valid = 0;
    t0 = cyc;
    n = 0;
    while (bus.err[ERR_TO] !== 1'b1 && n < TIMEOUT + 20) begin step(); n++; end
    checks++;
    if (bus.err !== 3'b100 || n != TIMEOUT) begin
      failures++; $display("FAIL timeout got err=%b after=%0d exp err=100 after=%0d", bus.err, cyc - t0, TIMEOUT);
    end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL timeout_idle got busy=%b exp=0", bus.busy); end
    bus.s_valid = 1; bus.s_data = DW'($urandom); step(); bus.s_valid = 0;
    checks++;
    if (bus.fir_valid_in !== 1'b1) begin failures++; $display("FAIL timeout_reissue got=%b exp=1", bus.fir_valid_in); end
    bus.fir_valid_out = 1; bus.err_clr = 1; step(); bus.fir_valid_out = 0; bus.err_clr = 0;
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    int nb, bad;
    logic [2*DW+AW+15:0] outs;
    for (int i = 0; i < 4; i++) write_bank(i, 16'h7F7F);
    clear_q();
    pulse_commit();
    wait_cload(ok);
    repeat (20) step();
    rstn = 0;
    #1;
    outs = {bus.fir_din, bus.fir_valid_in, bus.fir_cin, bus.fir_caddr, bus.fir_cload,
            bus.load_done, bus.busy, bus.err, 8'h00};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL midload_reset_outputs got=%h exp=0", outs); end
    repeat (2) step();
    rstn = 1;
    for (int i = 0; i < NUM_TAPS; i++) model_bank[i] = '0;
    nb = ld_addr_q.size();
    repeat (80) step();
    checks++;
    if (done_cyc_q.size() != 0 || ld_addr_q.size() != nb || bus.busy !== 1'b0) begin
      failures++; $display("FAIL midload_abort got done=%0d extra_beats=%0d busy=%b exp 0 0 0",
                           done_cyc_q.size(), ld_addr_q.size() - nb, bus.busy);
    end
    clear_q();
    pulse_commit();
    wait_done(ok);
    step();
    bad = 0;
    foreach (ld_data_q[i]) if (ld_data_q[i] !== model_bank[ld_addr_q[i]]) bad++;
    checks++;
    if (ld_addr_q.size() != NUM_TAPS || bad != 0) begin
      failures++; $display("FAIL midload_recommit got beats=%0d nonzero=%0d exp beats=%0d nonzero=0",
                           ld_addr_q.size(), bad, NUM_TAPS);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_sample();
    test_commit_in_run();
    test_hold();
    test_hostwr_load();
    test_timeout();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
